// File: rtl/spi_point_receiver.sv
// SPI mode-0 slave that turns 56-bit point records into 64-bit framebuffer BRAM writes.
// One chip-select low period is one frame; the write address restarts at 0 on every frame.
module spi_point_receiver #(
  parameter int ADDR_WIDTH  = 15,
  parameter int WORD_BITS   = 56,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  sclk_in,
  input  logic                  mosi_in,
  input  logic                  cs_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [63:0]           bram_data_out,
  output logic                  bram_we_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic                  frame_error_out,
  output logic                  overflow_out,
  output logic [ADDR_WIDTH:0]   point_count_out
);

  localparam int CNT_W  = $clog2(WORD_BITS + 1);
  localparam int WAIT_W = $clog2(SYNC_STAGES + 1);

  localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(WORD_BITS);
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0]     WAIT_DONE = WAIT_W'(SYNC_STAGES);
  localparam logic [WAIT_W-1:0]     WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH:0]   RUN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   RUN_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};

  localparam logic [2:0] ST_WAIT_IDLE = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_RECV      = 3'd2;
  localparam logic [2:0] ST_WRITE     = 3'd3;
  localparam logic [2:0] ST_END       = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, cs_sync_r;
  logic                   sclk_prev_r, cs_prev_r;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise_s, cs_rise_s, cs_fall_s;

  logic [2:0]             state_r;
  logic [WAIT_W-1:0]      wait_cnt_r;
  logic [WORD_BITS-1:0]   shift_r;
  logic [CNT_W-1:0]       bit_cnt_r;
  logic [ADDR_WIDTH-1:0]  addr_r;
  logic [ADDR_WIDTH:0]    run_cnt_r;
  logic                   cs_pend_r;

  logic [WORD_BITS-1:0]   shift_next_s;
  logic [CNT_W-1:0]       bit_cnt_inc_s;
  logic [ADDR_WIDTH:0]    run_cnt_inc_s;

  assign sclk_s = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s   = cs_sync_r[SYNC_STAGES-1];

  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign cs_rise_s   = cs_s & ~cs_prev_r;
  assign cs_fall_s   = ~cs_s & cs_prev_r;

  // Input synchronizers and one-cycle-delayed copies for edge detection
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      cs_sync_r   <= '1;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk_in};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_in};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_in};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  // Next-value helpers for the shifter and the saturating point counter
  always_comb begin
    shift_next_s  = {shift_r[WORD_BITS-2:0], mosi_s};
    bit_cnt_inc_s = bit_cnt_r + CNT_ONE;
    if (run_cnt_r == RUN_MAX) begin
      run_cnt_inc_s = run_cnt_r;
    end else begin
      run_cnt_inc_s = run_cnt_r + RUN_ONE;
    end
  end

  // Frame FSM; WAIT_IDLE first lets the synchronizers fill so a frame in progress at reset is skipped
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_r         <= ST_WAIT_IDLE;
      wait_cnt_r      <= '0;
      shift_r         <= '0;
      bit_cnt_r       <= '0;
      addr_r          <= '0;
      run_cnt_r       <= '0;
      cs_pend_r       <= 1'b0;
      bram_addr_out   <= '0;
      bram_data_out   <= 64'h0;
      bram_we_out     <= 1'b0;
      busy_out        <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      overflow_out    <= 1'b0;
      point_count_out <= '0;
    end else begin
      bram_we_out     <= 1'b0;
      frame_done_out  <= 1'b0;
      frame_error_out <= 1'b0;
      case (state_r)
        ST_WAIT_IDLE: begin
          if (wait_cnt_r != WAIT_DONE) begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end else if (cs_s) begin
            state_r <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (cs_fall_s) begin
            shift_r      <= '0;
            bit_cnt_r    <= '0;
            addr_r       <= '0;
            run_cnt_r    <= '0;
            cs_pend_r    <= 1'b0;
            overflow_out <= 1'b0;
            busy_out     <= 1'b1;
            state_r      <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (sclk_rise_s) begin
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_inc_s;
            if (bit_cnt_inc_s == CNT_FULL) begin
              bram_data_out <= {{(64-WORD_BITS){1'b0}}, shift_next_s};
              bram_addr_out <= addr_r;
              bram_we_out   <= 1'b1;
              cs_pend_r     <= cs_rise_s;
              state_r       <= ST_WRITE;
            end else if (cs_rise_s) begin
              frame_error_out <= 1'b1;
              busy_out        <= 1'b0;
              state_r         <= ST_END;
            end
          end else if (cs_rise_s) begin
            if (bit_cnt_r == '0) begin
              frame_done_out  <= 1'b1;
              point_count_out <= run_cnt_r;
            end else begin
              frame_error_out <= 1'b1;
            end
            busy_out <= 1'b0;
            state_r  <= ST_END;
          end
        end
        ST_WRITE: begin
          addr_r    <= addr_r + ADDR_ONE;
          run_cnt_r <= run_cnt_inc_s;
          bit_cnt_r <= '0;
          cs_pend_r <= 1'b0;
          if (addr_r == ADDR_LAST) begin
            overflow_out <= 1'b1;
          end
          if (cs_pend_r || cs_rise_s) begin
            frame_done_out  <= 1'b1;
            point_count_out <= run_cnt_inc_s;
            busy_out        <= 1'b0;
            state_r         <= ST_END;
          end else begin
            state_r <= ST_RECV;
          end
        end
        ST_END: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_WAIT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_point_receiver.sv
// Randomized bench for spi_point_receiver: a default instance and an ADDR_WIDTH=2 instance share one SPI bus.
module tb_spi_point_receiver;

  logic clock_in = 1'b0;
  logic reset_in, sclk_in, mosi_in, cs_in;

  logic [14:0] addr0;  logic [63:0] data0;  logic we0, busy0, done0, err0, ovf0;  logic [15:0] cnt0;
  logic [1:0]  addr1;  logic [63:0] data1;  logic we1, busy1, done1, err1, ovf1;  logic [2:0]  cnt1;

  spi_point_receiver u_dut (
    .clock_in(clock_in), .reset_in(reset_in), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_in(cs_in),
    .bram_addr_out(addr0), .bram_data_out(data0), .bram_we_out(we0), .busy_out(busy0),
    .frame_done_out(done0), .frame_error_out(err0), .overflow_out(ovf0), .point_count_out(cnt0)
  );

  spi_point_receiver #(.ADDR_WIDTH(2)) u_dut_small (
    .clock_in(clock_in), .reset_in(reset_in), .sclk_in(sclk_in), .mosi_in(mosi_in), .cs_in(cs_in),
    .bram_addr_out(addr1), .bram_data_out(data1), .bram_we_out(we1), .busy_out(busy1),
    .frame_done_out(done1), .frame_error_out(err1), .overflow_out(ovf1), .point_count_out(cnt1)
  );

  always #5 clock_in = ~clock_in;

  typedef struct { logic [14:0] addr; logic [63:0] data; logic ovf; } wr_t;
  typedef struct { logic done; logic [15:0] cnt; logic ovf; } fr_t;

  wr_t         wr_q0[$], wr_q1[$];
  fr_t         fr_q0[$], fr_q1[$];
  logic [55:0] recs[$];
  int          last_cnt[2];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: word i lands at i mod 2^aw; the wrap out of the last address flags overflow
  task automatic model_frame(input int id, input int aw, input int extra);
    int  cap;
    wr_t w;
    fr_t f;
    cap = 1 << aw;
    for (int i = 0; i < recs.size(); i++) begin
      w.addr = 15'(i % cap);
      w.data = {8'h00, recs[i]};
      w.ovf  = (i >= cap);
      if (id == 0) wr_q0.push_back(w); else wr_q1.push_back(w);
    end
    f.ovf = (recs.size() >= cap);
    if (extra == 0) begin
      f.done = 1'b1;
      last_cnt[id] = (recs.size() < cap) ? recs.size() : cap;
    end else begin
      f.done = 1'b0;
    end
    f.cnt = 16'(last_cnt[id]);
    if (id == 0) fr_q0.push_back(f); else fr_q1.push_back(f);
  endtask

  task automatic mon(input int id, input logic we, input logic [14:0] a, input logic [63:0] d,
                     input logic busy, input logic done, input logic err, input logic ovf,
                     input logic [15:0] cnt);
    wr_t w;
    fr_t f;
    if (we) begin
      if ((id == 0 && wr_q0.size() == 0) || (id == 1 && wr_q1.size() == 0)) begin
        flag($sformatf("unexpected_write[%0d] addr=%h data=%h", id, a, d));
      end else begin
        if (id == 0) w = wr_q0.pop_front(); else w = wr_q1.pop_front();
        check($sformatf("write_addr[%0d]", id), 64'(a), 64'(w.addr));
        check($sformatf("write_data[%0d]", id), d, w.data);
        check($sformatf("write_overflow[%0d]", id), 64'(ovf), 64'(w.ovf));
        check($sformatf("write_busy[%0d]", id), 64'(busy), 64'd1);
      end
    end
    if (done || err) begin
      if ((id == 0 && fr_q0.size() == 0) || (id == 1 && fr_q1.size() == 0)) begin
        flag($sformatf("unexpected_frame_end[%0d] done=%b err=%b", id, done, err));
      end else begin
        if (id == 0) f = fr_q0.pop_front(); else f = fr_q1.pop_front();
        check($sformatf("frame_done[%0d]", id), 64'(done), 64'(f.done));
        check($sformatf("frame_error[%0d]", id), 64'(err), 64'(!f.done));
        check($sformatf("point_count[%0d]", id), 64'(cnt), 64'(f.cnt));
        check($sformatf("frame_overflow[%0d]", id), 64'(ovf), 64'(f.ovf));
      end
    end
  endtask

  // Monitor: compare whatever either instance presents against the scoreboard
  always @(negedge clock_in) begin
    if (!reset_in) begin
      mon(0, we0, addr0, data0, busy0, done0, err0, ovf0, cnt0);
      mon(1, we1, 15'(addr1), data1, busy1, done1, err1, ovf1, 16'(cnt1));
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic send_bit(input logic b, input logic raise_cs);
    mosi_in = b;
    clk_wait(3);
    sclk_in = 1'b1;
    if (raise_cs) cs_in = 1'b1;
    clk_wait(3);
    sclk_in = 1'b0;
  endtask

  task automatic run_frame(input int extra, input bit same_edge);
    logic [55:0] r;
    logic [55:0] xr;
    model_frame(0, 15, extra);
    model_frame(1, 2, extra);
    xr = 56'({$urandom(), $urandom()});
    cs_in = 1'b0;
    clk_wait(4);
    for (int i = 0; i < recs.size(); i++) begin
      r = recs[i];
      for (int b = 55; b >= 0; b--) begin
        send_bit(r[b], same_edge && (i == recs.size() - 1) && (b == 0));
      end
    end
    for (int b = 0; b < extra; b++) send_bit(xr[55-b], 1'b0);
    clk_wait(3);
    cs_in = 1'b1;
    clk_wait(8);
    recs.delete();
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) recs.push_back(56'({$urandom(), $urandom()}));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr0"}, 64'(addr0), 64'd0);   check({tag, "_addr1"}, 64'(addr1), 64'd0);
    check({tag, "_data0"}, data0, 64'd0);        check({tag, "_data1"}, data1, 64'd0);
    check({tag, "_we0"}, 64'(we0), 64'd0);       check({tag, "_we1"}, 64'(we1), 64'd0);
    check({tag, "_busy0"}, 64'(busy0), 64'd0);   check({tag, "_busy1"}, 64'(busy1), 64'd0);
    check({tag, "_done0"}, 64'(done0), 64'd0);   check({tag, "_done1"}, 64'(done1), 64'd0);
    check({tag, "_err0"}, 64'(err0), 64'd0);     check({tag, "_err1"}, 64'(err1), 64'd0);
    check({tag, "_ovf0"}, 64'(ovf0), 64'd0);     check({tag, "_ovf1"}, 64'(ovf1), 64'd0);
    check({tag, "_cnt0"}, 64'(cnt0), 64'd0);     check({tag, "_cnt1"}, 64'(cnt1), 64'd0);
  endtask

  initial begin
    int n;
    int extra;
    int drain;
    logic [55:0] junk;
    reset_in = 1'b1;
    sclk_in  = 1'b0;
    mosi_in  = 1'b0;
    cs_in    = 1'b1;
    last_cnt[0] = 0;
    last_cnt[1] = 0;
    clk_wait(3);
    check_reset_outputs("reset");
    reset_in = 1'b0;
    clk_wait(6);

    recs.push_back(56'h1234ABCD112233);
    run_frame(0, 1'b0);

    add_random(3);
    run_frame(0, 1'b0);
    add_random(1);
    run_frame(0, 1'b0);

    add_random(1);
    run_frame(30, 1'b0);

    add_random(6);
    run_frame(0, 1'b0);
    add_random(1);
    run_frame(0, 1'b0);

    // Reset in the middle of a word with CS held low; nothing may come out of it
    junk = 56'({$urandom(), $urandom()});
    cs_in = 1'b0;
    clk_wait(4);
    for (int b = 0; b < 20; b++) send_bit(junk[b], 1'b0);
    reset_in = 1'b1;
    clk_wait(2);
    check_reset_outputs("midreset");
    reset_in = 1'b0;
    last_cnt[0] = 0;
    last_cnt[1] = 0;
    for (int b = 20; b < 56; b++) send_bit(junk[b], 1'b0);
    for (int b = 0; b < 20; b++) send_bit(junk[b], 1'b0);
    clk_wait(3);
    cs_in = 1'b1;
    clk_wait(8);
    add_random(1);
    run_frame(0, 1'b0);

    add_random(2);
    run_frame(0, 1'b1);

    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 5);
      extra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 55) : 0;
      add_random(n);
      run_frame(extra, 1'b0);
    end

    drain = 0;
    while ((wr_q0.size() + wr_q1.size() + fr_q0.size() + fr_q1.size()) != 0 && drain < 100) begin
      clk_wait(1);
      drain++;
    end
    checks++;
    if ((wr_q0.size() + wr_q1.size() + fr_q0.size() + fr_q1.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d writes and %0d/%0d frame ends outstanding, expected 0",
               wr_q0.size(), wr_q1.size(), fr_q0.size(), fr_q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_point_receiver.md
# spi_point_receiver

SPI slave that accepts laser point records from an upstream SPI master and writes them into the 64-bit point framebuffer BRAM that the display path reads. It is the writer side of the framebuffer: each 56-bit record (X, Y, B, G, R) becomes one BRAM word in the same field layout the display path unpacks. One chip-select assertion carries one frame, and the write address restarts at 0 on every frame.

## Interface
Parameters:
- ADDR_WIDTH, 15, BRAM address width; the frame holds at most 2^ADDR_WIDTH points.
- WORD_BITS, 56, bits per point record on the wire (16 X + 16 Y + 8 B + 8 G + 8 R).
- SYNC_STAGES, 2, flip-flop stages on each SPI input, minimum 2.

Ports:
- clock_in, input, 1, system clock.
- reset_in, input, 1, asynchronous, active-high reset.
- sclk_in, input, 1, SPI clock from the master; mode 0, data sampled on the rising edge.
- mosi_in, input, 1, SPI data, MSB first.
- cs_in, input, 1, active-low chip select; one low period is one frame.
- bram_addr_out, output, ADDR_WIDTH, BRAM write address.
- bram_data_out, output, 64, write data: [63:56]=0, [55:40]=X, [39:24]=Y, [23:16]=B, [15:8]=G, [7:0]=R.
- bram_we_out, output, 1, write strobe, one cycle per point.
- busy_out, output, 1, high while a frame is being received.
- frame_done_out, output, 1, one-cycle pulse at a clean frame end.
- frame_error_out, output, 1, one-cycle pulse at a frame end that left a partial word.
- overflow_out, output, 1, sticky; set when the address wraps within a frame.
- point_count_out, output, ADDR_WIDTH+1, number of points written in the last completed frame.

## Operation
- Synchronizers: sclk_in, mosi_in and cs_in each pass through SYNC_STAGES flops. The block acts only on the synchronized copies (sclk_s, mosi_s, cs_s).
- Edge detect: a registered copy of sclk_s and of cs_s gives a rise strobe for sclk and a fall strobe and a rise strobe for cs.
- States:
  - WAIT_IDLE: entered from reset. Moves to IDLE once cs_s=1. This stops the block from joining a frame partway through.
  - IDLE: on the cs_s falling edge, clear the shift register, bit count, address, running point count and overflow_out; set busy_out=1; go to RECV.
  - RECV: on each sclk_s rising edge, shift mosi_s into the LSB of the shift register and add 1 to the bit count.
    - When the bit count reaches WORD_BITS, register {8'h00, shift register} onto bram_data_out and the current address onto bram_addr_out, then go to WRITE.
    - On the cs_s rising edge, go to END.
  - WRITE: for one cycle:
    - bram_we_out=1;
    - address increments by 1, modulo 2^ADDR_WIDTH; the step from 2^ADDR_WIDTH-1 to 0 sets overflow_out;
    - running point count increments and saturates at 2^ADDR_WIDTH;
    - bit count clears.
    - Then go to RECV, or to END if a cs_s rising edge was latched during this cycle.
  - END: for one cycle:
    - if the bit count is 0, pulse frame_done_out and load point_count_out with the running count;
    - otherwise pulse frame_error_out, discard the partial word and leave point_count_out unchanged;
    - busy_out=0; go to IDLE.
- Same-cycle events: if an sclk_s rise and a cs_s rise occur in the same cycle, the bit is taken first. If that bit completes a word, the word is written (WRITE) before END.
- SCLK edges seen in IDLE or WAIT_IDLE are ignored.

## Timing
- Reset (asynchronous) sets every output to 0: addresses, data, strobes, counts and overflow_out. The state goes to WAIT_IDLE and the synchronizer flops clear to sclk=0, mosi=0, cs=1.
- Latency from a raw sclk_in edge to its sync-domain rise strobe: SYNC_STAGES+1 clocks.
- bram_we_out rises 1 clock after the rise strobe of the final bit. Address and data are stable from that cycle and through the strobe.
- frame_done_out and frame_error_out assert 1 clock after the cs_s rise strobe, or 2 clocks when a WRITE is pending.
- Minimum gap between records: none. Back-to-back words are allowed, because WRITE lasts 1 cycle and a bit takes at least 4 clocks.
- The SPI clock must satisfy f_sclk ≤ f_clock/4, with sclk high and low each lasting at least 2 clocks. Behaviour above this rate is undefined.
- mosi_in must be stable for at least SYNC_STAGES+1 clocks around each sclk rising edge. Mode-0 masters that change data on the falling edge meet this at the rate limit above.

## Test plan
- One point, 0x1234/0xABCD/B=0x11/G=0x22/R=0x33 -> one write: addr 0, data 0x001234ABCD112233. Then frame_done_out, point_count_out=1, frame_error_out=0.
- Three back-to-back points in one CS period -> writes at addresses 0, 1, 2 with matching data, then point_count_out=3. A second frame restarts at address 0.
- CS released after 30 bits of the second point -> exactly one write, then frame_error_out pulses and point_count_out keeps its previous value.
- ADDR_WIDTH=2, six points -> addresses 0,1,2,3,0,1; overflow_out=1, point_count_out=4 (saturated). overflow_out clears at the next CS fall.
- reset_in asserted mid-word while CS stays low, then more clocks -> no writes and no pulses. After CS goes high then low, the next point lands at address 0.
- sclk edge and CS rise land in the same synchronized cycle on bit 56 -> the word is written, then frame_done_out, not frame_error_out.
